// File: rtl/dcache_line_ctrl_pkg.sv
// Shared types and geometry helpers for the direct-mapped read-only data cache.
package dcache_line_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    REFILL   = 3'd3,
    RESP     = 3'd4,
    FLUSH    = 3'd5
  } dcache_state_e;

  // Tag width left over once line offset and index bits are removed
  function automatic int BASIC_TAG_WIDTH(input int max_mem, input int cache_widthe,
                                         input int cache_deepthe);
    return max_mem - cache_widthe - cache_deepthe;
  endfunction

  // Word width in bits for a bus of 2**bus_bytese bytes
  function automatic int BYTESE_BITS(input int bus_bytese);
    return 8 << bus_bytese;
  endfunction

  // Number of bus beats needed to fill one line
  function automatic int DCACHE_BEATS(input int cache_widthe, input int bus_bytese);
    return 1 << (cache_widthe - bus_bytese);
  endfunction

endpackage

// File: rtl/dcache_line_ctrl_tag_array.sv
// Valid/tag storage for the direct-mapped cache: combinational read, single
// synchronous write port and a one-cycle clear of every valid bit.
module dcache_tag_array
  import dcache_line_ctrl_pkg::*;
#(
  parameter int TAG_W = 21,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr_all
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  // Valid bits: reset and flush clear everything, otherwise one line is updated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // Tags only change when a line becomes valid; invalidation leaves them alone
  always_ff @(posedge clk) begin
    if (wr_en && wr_valid) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/dcache_line_ctrl.sv
// Blocking controller for a direct-mapped read-only cache with an external
// data SRAM and a burst refill port.
// Optional hit/miss statistics are built when DCACHE_STAT_EN is defined.
module dcache_line_ctrl
  import dcache_line_ctrl_pkg::*;
#(
  parameter int MAX_MEM       = 32,
  parameter int CACHE_WIDTHE  = 5,
  parameter int CACHE_DEEPTHE = 6,
  parameter int BUS_BYTESE    = 2,
  localparam int TAG_W  = BASIC_TAG_WIDTH(MAX_MEM, CACHE_WIDTHE, CACHE_DEEPTHE),
  localparam int W      = BYTESE_BITS(BUS_BYTESE),
  localparam int BEATS  = DCACHE_BEATS(CACHE_WIDTHE, BUS_BYTESE),
  localparam int BEAT_W = CACHE_WIDTHE - BUS_BYTESE
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [MAX_MEM-1:0]              req_addr,
  input  logic                            flush,
  output logic                            resp_valid,
  output logic [W-1:0]                    resp_data,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [MAX_MEM-1:0]              mem_req_addr,
  input  logic                            mem_rdata_valid,
  input  logic [W-1:0]                    mem_rdata,
  output logic                            dram_en,
  output logic                            dram_we,
  output logic [CACHE_DEEPTHE+BEAT_W-1:0] dram_addr,
  output logic [W-1:0]                    dram_wdata,
  input  logic [W-1:0]                    dram_rdata
`ifdef DCACHE_STAT_EN
  ,
  output logic [31:0]                     hit_cnt,
  output logic [31:0]                     miss_cnt
`endif
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  dcache_state_e              state_q;
  logic [TAG_W-1:0]           req_tag_q;
  logic [CACHE_DEEPTHE-1:0]   req_idx_q;
  logic [BEAT_W-1:0]          req_word_q;
  logic [BEAT_W-1:0]          beat_q;
  logic [W-1:0]               crit_q;
  logic                       flush_pend_q;

  logic                       accept;
  logic                       lookup_hit;
  logic                       hit;
  logic                       last_beat;
  logic                       tag_rd_valid;
  logic [TAG_W-1:0]           tag_rd_tag;
  logic                       tag_wr_en;
  logic                       addr_unused;

  // Byte-within-word bits never matter for word loads
  assign addr_unused = ^req_addr[BUS_BYTESE-1:0];

  assign req_ready  = (state_q == IDLE) && !flush && !flush_pend_q;
  assign accept     = req_valid && req_ready;
  assign lookup_hit = tag_rd_valid && (tag_rd_tag == req_tag_q);
  assign hit        = (state_q == LOOKUP) && lookup_hit;
  assign last_beat  = (state_q == REFILL) && mem_rdata_valid && (beat_q == LAST_BEAT);

  // The line is invalidated when its refill is granted and validated on the final beat
  assign tag_wr_en = ((state_q == MISS_REQ) && mem_req_ready) || last_beat;

  dcache_tag_array #(
    .TAG_W (TAG_W),
    .IDX_W (CACHE_DEEPTHE)
  ) u_tag_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (req_idx_q),
    .rd_valid (tag_rd_valid),
    .rd_tag   (tag_rd_tag),
    .wr_en    (tag_wr_en),
    .wr_idx   (req_idx_q),
    .wr_valid (state_q == REFILL),
    .wr_tag   (req_tag_q),
    .clr_all  (state_q == FLUSH)
  );

  // Main sequencer: lookup, refill handshake, beat counting and flush ordering
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      req_word_q   <= '0;
      beat_q       <= '0;
      crit_q       <= '0;
      flush_pend_q <= 1'b0;
      mem_req_addr <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush || flush_pend_q) begin
            state_q <= FLUSH;
          end else if (req_valid) begin
            req_tag_q  <= req_addr[MAX_MEM-1 -: TAG_W];
            req_idx_q  <= req_addr[CACHE_WIDTHE +: CACHE_DEEPTHE];
            req_word_q <= req_addr[BUS_BYTESE +: BEAT_W];
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_hit) begin
            state_q <= IDLE;
          end else begin
            mem_req_addr <= {req_tag_q, req_idx_q, {CACHE_WIDTHE{1'b0}}};
            state_q      <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            beat_q  <= '0;
            state_q <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rdata_valid) begin
            if (beat_q == req_word_q) begin
              crit_q <= mem_rdata;
            end
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              state_q <= RESP;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        FLUSH: begin
          flush_pend_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (flush && (state_q != IDLE) && (state_q != FLUSH)) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  // SRAM port: read the requested word on accept, write each refill beat
  always_comb begin
    dram_en    = 1'b0;
    dram_we    = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    if (accept) begin
      dram_en   = 1'b1;
      dram_addr = {req_addr[CACHE_WIDTHE +: CACHE_DEEPTHE], req_addr[BUS_BYTESE +: BEAT_W]};
    end else if ((state_q == REFILL) && mem_rdata_valid) begin
      dram_en    = 1'b1;
      dram_we    = 1'b1;
      dram_addr  = {req_idx_q, beat_q};
      dram_wdata = mem_rdata;
    end
  end

  // Responses come straight from the SRAM on a hit or from the captured word after refill
  always_comb begin
    resp_valid    = hit || (state_q == RESP);
    resp_data     = '0;
    mem_req_valid = (state_q == MISS_REQ);
    if (state_q == RESP) begin
      resp_data = crit_q;
    end else if (hit) begin
      resp_data = dram_rdata;
    end
  end

`ifdef DCACHE_STAT_EN
  // Saturating hit/miss counters, counted at lookup and kept across flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == LOOKUP) begin
      if (lookup_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// Directed scoreboard bench for dcache_line_ctrl (default geometry: 21-bit tag, 8 beats).
module tb_dcache_line_ctrl;

  typedef struct {
    logic [31:0] data;
    bit          isHit;
  } sb_item_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        dram_en;
  logic        dram_we;
  logic [8:0]  dram_addr;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
`ifdef DCACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int acceptCyc  = 0;
  int memReqCycles = 0;
  int wrCount    = 0;

  sb_item_t    sb [$];
  sb_item_t    item;
  logic [31:0] sram [0:511];

  dcache_line_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .flush           (flush),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .dram_en         (dram_en),
    .dram_we         (dram_we),
    .dram_addr       (dram_addr),
    .dram_wdata      (dram_wdata),
    .dram_rdata      (dram_rdata)
`ifdef DCACHE_STAT_EN
    ,
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data SRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (dram_en) begin
      if (dram_we) sram[dram_addr] <= dram_wdata;
      else         dram_rdata      <= sram[dram_addr];
    end
  end

  // Backing memory contents: line 0x420 holds 0xA0..0xA7, others hold line address + beat
  function automatic logic [31:0] memWord(input logic [31:0] line, input int beat);
    if (line == 32'h0000_0420) return 32'hA0 + 32'(beat);
    return line + 32'(beat);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: mid-cycle sampling of handshakes, SRAM writes and responses
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (req_valid && req_ready) acceptCyc = cyc;
      if (mem_req_valid) memReqCycles++;
      if (dram_en && dram_we) wrCount++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("resp_without_request", 32'(sb.size()), 32'd1);
        end else begin
          item = sb.pop_front();
          checkOutput("resp_data", resp_data, item.data);
          if (item.isHit) checkOutput("hit_latency", 32'(cyc - acceptCyc), 32'd1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expData, input bit isHit);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    sb.push_back('{data: expData, isHit: isHit});
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("req_accept_bound", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic serveRefill(input logic [31:0] line, input int stall, input int flushBeat,
                             input int resetBeat);
    int n = 0;
    int w0;
    while (!mem_req_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("mem_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("mem_req_addr", mem_req_addr, line);
    w0 = wrCount;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput("stall_valid", 32'(mem_req_valid), 32'd1);
      checkOutput("stall_addr", mem_req_addr, line);
    end
    if (stall > 0) checkOutput("stall_no_write", 32'(wrCount - w0), 32'd0);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == resetBeat) begin
        mem_rdata_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_mem_req_addr", mem_req_addr, 32'd0);
        checkOutput("rst_dram_en", 32'(dram_en), 32'd0);
        checkOutput("rst_dram_we", 32'(dram_we), 32'd0);
        checkOutput("rst_dram_addr", 32'(dram_addr), 32'd0);
        checkOutput("rst_dram_wdata", dram_wdata, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        w0 = wrCount;
        for (int bb = b; bb < 8; bb++) begin
          mem_rdata_valid = 1'b1;
          mem_rdata       = memWord(line, bb);
          @(posedge clk); #1;
        end
        mem_rdata_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("stray_beats_no_write", 32'(wrCount - w0), 32'd0);
        checkOutput("stray_beats_no_resp", 32'(sb.size()), 32'd0);
        checkOutput("post_reset_ready", 32'(req_ready), 32'd1);
        return;
      end
      mem_rdata_valid = 1'b1;
      mem_rdata       = memWord(line, b);
      flush           = (b == flushBeat);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    mem_rdata_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int m0;
    int w0;
    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_addr        = '0;
    flush           = 1'b0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("reset_mem_req_addr", mem_req_addr, 32'd0);
    checkOutput("reset_dram_en", 32'(dram_en), 32'd0);

    $display("[TB] cold miss");
    w0 = wrCount;
    applyStimulus(32'h0000_0424, 32'hA1, 1'b0);
    serveRefill(32'h0000_0420, 0, -1, -1);
    waitDrain();
    checkOutput("cold_write_count", 32'(wrCount - w0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("cold_sram_word", sram[9'(264 + i)], 32'hA0 + 32'(i));
    end

    $display("[TB] hit");
    m0 = memReqCycles;
    applyStimulus(32'h0000_042C, 32'hA3, 1'b1);
    @(posedge clk); #1;
    checkOutput("hit_no_mem_req", 32'(memReqCycles - m0), 32'd0);
    checkOutput("hit_drained", 32'(sb.size()), 32'd0);

    $display("[TB] conflict");
    applyStimulus(32'h0000_0C24, 32'h0000_0C21, 1'b0);
    serveRefill(32'h0000_0C20, 0, -1, -1);
    waitDrain();

    $display("[TB] conflict re-miss with stalled refill grant");
    applyStimulus(32'h0000_0424, 32'hA1, 1'b0);
    serveRefill(32'h0000_0420, 5, -1, -1);
    waitDrain();

    $display("[TB] flush during refill");
    applyStimulus(32'h0000_0844, 32'h0000_0841, 1'b0);
    serveRefill(32'h0000_0840, 0, 3, -1);
    @(posedge clk); #1;
    checkOutput("flush_pend_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("flush_cycle_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("post_flush_ready", 32'(req_ready), 32'd1);
    checkOutput("flush_resp_drained", 32'(sb.size()), 32'd0);
    applyStimulus(32'h0000_0424, 32'hA1, 1'b0);
    serveRefill(32'h0000_0420, 0, -1, -1);
    waitDrain();

    $display("[TB] hit on last word");
    m0 = memReqCycles;
    applyStimulus(32'h0000_043C, 32'hA7, 1'b1);
    @(posedge clk); #1;
    checkOutput("last_word_no_mem_req", 32'(memReqCycles - m0), 32'd0);

    $display("[TB] reset during refill");
    applyStimulus(32'h0000_1464, 32'h0000_1461, 1'b0);
    serveRefill(32'h0000_1460, 0, -1, 4);
    applyStimulus(32'h0000_0424, 32'hA1, 1'b0);
    serveRefill(32'h0000_0420, 0, -1, -1);
    waitDrain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
